board_ram_arbiter: RTL

Shares the single-port 6-bit board RAM (250 cells, 8-bit address) between three masters: the RAM clear engine (port 0), game logic (port 1) and the display reader (port 2). It grants one master at a time with round-robin priority and optional hold limit. It registers the winner's address, write-enable and data onto the RAM port, and routes read data back to the issuing master with a valid strobe.

---
 rtl/board_ram_arbiter_if.sv | 28 ++
 rtl/board_ram_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/board_ram_arbiter_if.sv
// Bus bundle between the three board-RAM masters, the arbiter and the RAM port.
// Per-master request/address/data lanes in, grant and routed read data out.
interface board_ram_arbiter_if;
  logic [2:0] req;
  logic [7:0] addr0, addr1, addr2;
  logic       wren0, wren1, wren2;
  logic [5:0] data0, data1, data2;
  logic [2:0] gnt;
  logic [7:0] ram_addr;
  logic       ram_wren;
  logic [5:0] ram_data;
  logic [5:0] ram_q;
  logic [5:0] rd_data;
  logic [2:0] rd_valid;
  logic       err;

  modport slave (
    input  req, addr0, addr1, addr2, wren0, wren1, wren2,
           data0, data1, data2, ram_q,
    output gnt, ram_addr, ram_wren, ram_data, rd_data, rd_valid, err
  );

  modport master (
    output req, addr0, addr1, addr2, wren0, wren1, wren2,
           data0, data1, data2, ram_q,
    input  gnt, ram_addr, ram_wren, ram_data, rd_data, rd_valid, err
  );
endinterface

// File: rtl/board_ram_arbiter.sv
// Round-robin arbiter sharing the single-port board RAM between clear engine,
// game logic and display reader; registers the RAM port and routes read data back.
module board_ram_arbiter #(
  parameter int RAM_DEPTH  = 250,
  parameter int RD_LATENCY = 1,
  parameter int MAX_HOLD   = 0
) (
  input logic               clk,
  input logic               reset,
  board_ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

  localparam int         HOLD_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [8:0] DEPTH  = 9'(RAM_DEPTH);

  state_t            state, state_nxt;
  logic [1:0]        owner, last_owner, pick;
  logic [1:0]        cand0, cand1, cand2;
  logic              pick_valid, take, beat;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_last;
  logic [7:0]        sel_addr;
  logic              sel_wren;
  logic [5:0]        sel_data;
  logic              own_req, in_range;
  logic [2:0]        rd_pipe [RD_LATENCY+1];

  function automatic logic [2:0] onehot(input logic [1:0] id);
    return 3'b001 << id;
  endfunction

  // Search order starts just after the last owner, so a master that keeps
  // requesting still yields to the others.
  // NOTE: every always_comb output gets a default first; a path that leaves one
  // unassigned would infer a latch.
  always_comb begin
    cand0 = 2'd0;
    cand1 = 2'd1;
    cand2 = 2'd2;
    case (last_owner)
      2'd0: begin cand0 = 2'd1; cand1 = 2'd2; cand2 = 2'd0; end
      2'd1: begin cand0 = 2'd2; cand1 = 2'd0; cand2 = 2'd1; end
      default: ;
    endcase
    pick_valid = |bus.req;
    if (bus.req[cand0])      pick = cand0;
    else if (bus.req[cand1]) pick = cand1;
    else                     pick = cand2;
  end

  always_comb begin
    sel_addr = bus.addr0;
    sel_wren = bus.wren0;
    sel_data = bus.data0;
    case (owner)
      2'd1: begin sel_addr = bus.addr1; sel_wren = bus.wren1; sel_data = bus.data1; end
      2'd2: begin sel_addr = bus.addr2; sel_wren = bus.wren2; sel_data = bus.data2; end
      default: ;
    endcase
  end

  assign own_req   = bus.req[owner];
  assign in_range  = {1'b0, sel_addr} < DEPTH;
  assign hold_last = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    beat      = 1'b0;
    case (state)
      OWN: begin
        if (!own_req) begin
          state_nxt = GAP;
        end else begin
          beat = 1'b1;
          if (hold_last) state_nxt = GAP;
        end
      end
      default: begin
        if (pick_valid) begin
          state_nxt = OWN;
          take      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      owner        <= 2'd0;
      last_owner   <= 2'd2;
      hold_cnt     <= '0;
      bus.gnt      <= '0;
      bus.ram_addr <= '0;
      bus.ram_wren <= 1'b0;
      bus.ram_data <= '0;
      bus.err      <= 1'b0;
    end else begin
      state        <= state_nxt;
      bus.ram_wren <= beat & sel_wren & in_range;
      bus.err      <= beat & ~in_range;
      if (beat) begin
        bus.ram_addr <= sel_addr;
        bus.ram_data <= sel_data;
        hold_cnt     <= hold_cnt + 1'b1;
      end
      if (take) begin
        owner      <= pick;
        last_owner <= pick;
        bus.gnt    <= onehot(pick);
        hold_cnt   <= '0;
      end else if (state_nxt != OWN) begin
        bus.gnt <= '0;
      end
    end
  end

  // Read-owner pipeline: tags each in-range read beat with its issuer so data
  // returning after a regrant still reaches the right master.
  // NOTE: this small tag pipeline is reset so a reset drops in-flight reads;
  // bulk storage would normally be left unreset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= RD_LATENCY; i++) rd_pipe[i] <= '0;
    end else begin
      rd_pipe[0] <= (beat && !sel_wren && in_range) ? onehot(owner) : 3'b000;
      for (int i = 1; i <= RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  assign bus.rd_valid = rd_pipe[RD_LATENCY];
  assign bus.rd_data  = bus.ram_q;

endmodule
